// File: rtl/mole_round_ctrl_pkg.sv
// Shared definitions for the whack-a-mole round controller: state encoding, LFSR taps, default timing.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package mole_round_ctrl_pkg;

   // Round states; the encoding is visible to the display stage, so it is fixed
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GAP  = 2'd1,
      ST_UP   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam int         DEF_NUM_MOLES  = 4;
   localparam int         DEF_MOLE_TICKS = 3;
   localparam int         DEF_GAP_TICKS  = 1;
   localparam int         DEF_SCORE_W    = 7;
   localparam int         DEF_SCORE_MAX  = 99;
   localparam logic [7:0] DEF_LFSR_SEED  = 8'hA5;
   localparam int         DEF_MAX_MISSES = 3;

   // Miss counter width; it saturates at all ones
   localparam int         MISS_W         = 4;

   // One step of the 8-bit Fibonacci LFSR: shift left, feedback into bit 0
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/mole_round_ctrl_btn_sync_edge.sv
// Button front end: per-bit 2-flop synchronizer followed by a rising-edge detector.
// Latency: press_o pulses for one clk, 2 clk edges after btn_i rises (judged at the 3rd edge).
// Backpressure: none; every rising edge produces exactly one pulse.
module mole_round_ctrl_btn_sync_edge #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] btn_i,
   output logic [W-1:0] press_o
);

   logic [W-1:0] sync1_q;
   logic [W-1:0] sync2_q;
   logic [W-1:0] prev_q;

   // Two-stage synchronizer plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: lights a pseudo-random mole per slot, judges presses, keeps score/misses.
// Latency: mole lights on the edge of the GAP_TICKS-th gap tick; a hit is scored 3 clk after the button rises.
// Backpressure: none; game_begin low in GAP/UP ends the round. Optional LIVES_EN macro adds a miss limit.
module mole_round_ctrl
   import mole_round_ctrl_pkg::*;
#(
   parameter int         NUM_MOLES  = DEF_NUM_MOLES,
   parameter int         MOLE_TICKS = DEF_MOLE_TICKS,
   parameter int         GAP_TICKS  = DEF_GAP_TICKS,
   parameter int         SCORE_W    = DEF_SCORE_W,
   parameter int         SCORE_MAX  = DEF_SCORE_MAX,
   parameter logic [7:0] LFSR_SEED  = DEF_LFSR_SEED,
   parameter int         MAX_MISSES = DEF_MAX_MISSES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 game_begin,
   input  logic [NUM_MOLES-1:0] btn,
   output logic [NUM_MOLES-1:0] mole,
   output logic [SCORE_W-1:0]   score,
   output logic [MISS_W-1:0]    misses,
   output logic                 hit_pulse,
   output logic                 round_active,
   output logic                 game_over
);

   localparam int IDX_W   = $clog2(NUM_MOLES);
   localparam int CNT_MAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Elaboration-time parameter sanity
   if (NUM_MOLES < 2 || NUM_MOLES > 8 || (NUM_MOLES & (NUM_MOLES - 1)) != 0) begin : g_chk_moles
      $error("mole_round_ctrl: NUM_MOLES must be a power of 2 in 2..8");
   end
   if (MOLE_TICKS < 1 || GAP_TICKS < 1) begin : g_chk_ticks
      $error("mole_round_ctrl: MOLE_TICKS and GAP_TICKS must be at least 1");
   end
   if (SCORE_MAX >= (1 << SCORE_W)) begin : g_chk_score
      $error("mole_round_ctrl: SCORE_MAX does not fit in SCORE_W bits");
   end
   if (MAX_MISSES < 1 || MAX_MISSES > 15) begin : g_chk_lives
      $error("mole_round_ctrl: MAX_MISSES must be in 1..15");
   end

   state_t               state_q;
   logic [7:0]           lfsr_q;
   logic                 gb_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic [NUM_MOLES-1:0] mole_q;
   logic [SCORE_W-1:0]   score_q;
   logic [MISS_W-1:0]    misses_q;
   logic                 hit_pulse_q;
`ifdef LIVES_EN
   logic                 game_over_q;
`endif

   logic [NUM_MOLES-1:0] press;
   logic [IDX_W-1:0]     cand;
   logic [IDX_W-1:0]     idx_d;
   logic [NUM_MOLES-1:0] idx_mask;
   logic                 gb_rise;
   logic                 hit;
   logic                 wrong;
   logic                 gap_done;
   logic                 up_timeout;
   logic [SCORE_W-1:0]   score_inc;
   logic [MISS_W-1:0]    misses_inc;

   mole_round_ctrl_btn_sync_edge #(
      .W (NUM_MOLES)
   ) u_btn (
      .clk     (clk),
      .rst_n   (reset),
      .btn_i   (btn),
      .press_o (press)
   );

   // Event decode: mole pick, press classification, tick terminal counts, saturating increments
   always_comb begin
      cand       = lfsr_q[IDX_W-1:0];
      idx_d      = (cand == idx_q) ? cand + IDX_W'(1) : cand;
      idx_mask   = NUM_MOLES'(1) << idx_q;
      gb_rise    = game_begin & ~gb_q;
      hit        = |(press & idx_mask);
      wrong      = |(press & ~idx_mask);
      gap_done   = tick && (cnt_q == CNT_W'(GAP_TICKS - 1));
      up_timeout = tick && (cnt_q == CNT_W'(MOLE_TICKS - 1));
      score_inc  = (score_q >= SCORE_W'(SCORE_MAX)) ? score_q : score_q + SCORE_W'(1);
      misses_inc = (misses_q == '1) ? misses_q : misses_q + MISS_W'(1);
   end

   // Round FSM with LFSR, tick counter and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= LFSR_SEED;
         gb_q        <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= '0;
         mole_q      <= '0;
         score_q     <= '0;
         misses_q    <= '0;
         hit_pulse_q <= 1'b0;
`ifdef LIVES_EN
         game_over_q <= 1'b0;
`endif
      end else begin
         gb_q        <= game_begin;
         lfsr_q      <= lfsr_next(lfsr_q);
         hit_pulse_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               mole_q <= '0;
               if (gb_rise) begin
                  score_q  <= '0;
                  misses_q <= '0;
                  cnt_q    <= '0;
                  state_q  <= ST_GAP;
`ifdef LIVES_EN
                  game_over_q <= 1'b0;
`endif
               end
            end
            ST_GAP: begin
               mole_q <= '0;
               if (!game_begin) begin
                  cnt_q   <= '0;
                  state_q <= ST_DONE;
`ifdef LIVES_EN
               end else if (misses_q >= MISS_W'(MAX_MISSES)) begin
                  cnt_q       <= '0;
                  state_q     <= ST_DONE;
                  game_over_q <= 1'b1;
`endif
               end else if (tick) begin
                  if (gap_done) begin
                     idx_q   <= idx_d;
                     mole_q  <= NUM_MOLES'(1) << idx_d;
                     cnt_q   <= '0;
                     state_q <= ST_UP;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_UP: begin
               if (!game_begin) begin
                  // Round ended by the begin controller; a same-cycle hit is dropped
                  mole_q  <= '0;
                  cnt_q   <= '0;
                  state_q <= ST_DONE;
`ifdef LIVES_EN
               end else if (misses_q >= MISS_W'(MAX_MISSES)) begin
                  mole_q      <= '0;
                  cnt_q       <= '0;
                  state_q     <= ST_DONE;
                  game_over_q <= 1'b1;
`endif
               end else if (hit) begin
                  // A correct press masks wrong presses and the timeout in the same cycle
                  score_q     <= score_inc;
                  hit_pulse_q <= 1'b1;
                  mole_q      <= '0;
                  cnt_q       <= '0;
                  state_q     <= ST_GAP;
               end else begin
                  if (wrong || up_timeout) begin
                     misses_q <= misses_inc;
                  end
                  if (up_timeout) begin
                     mole_q  <= '0;
                     cnt_q   <= '0;
                     state_q <= ST_GAP;
                  end else if (tick) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               mole_q  <= '0;
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mole         = mole_q;
   assign score        = score_q;
   assign misses       = misses_q;
   assign hit_pulse    = hit_pulse_q;
   assign round_active = (state_q == ST_GAP) || (state_q == ST_UP);
`ifdef LIVES_EN
   assign game_over    = game_over_q;
`else
   assign game_over    = 1'b0;
`endif

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Testbench for mole_round_ctrl: directed stimulus with a queue of expected output states.
// Latency: a monitor compares at every negedge where the observed outputs change.
// Backpressure: n/a; every wait on the DUT is bounded.
module tb_mole_round_ctrl;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       game_begin;
   logic [3:0] btn;
   logic [3:0] mole;
   logic [6:0] score;
   logic [3:0] misses;
   logic       hit_pulse;
   logic       round_active;
   logic       game_over;

   mole_round_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .game_begin   (game_begin),
      .btn          (btn),
      .mole         (mole),
      .score        (score),
      .misses       (misses),
      .hit_pulse    (hit_pulse),
      .round_active (round_active),
      .game_over    (game_over)
   );

   typedef struct {
      bit    lit;
      int    sc;
      int    mi;
      bit    hp;
      bit    go;
      string tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One-cycle tick every 8 clocks
   initial begin
      tick = 1'b0;
      forever begin
         repeat (7) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push(input bit lit, input int sc, input int mi, input bit hp, input bit go,
                       input string tag);
      exp_t e;
      e.lit = lit; e.sc = sc; e.mi = mi; e.hp = hp; e.go = go; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic wait_lit(input bit v, input string tag);
      int n = 0;
      while (((mole != 4'd0) != v) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if ((mole != 4'd0) != v) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_%s: timed out, mole=%b, required lit=%0d", tag, mole, v);
      end
   endtask

   // Counts consecutive negedges (including the current one) where lit == v
   task automatic count_lit(input bit v, output int n);
      n = 1;
      forever begin
         @(negedge clk);
         if (((mole != 4'd0) != v) || n >= 200) break;
         n++;
      end
   endtask

   task automatic wait_q_empty(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_%s: %0d expected events still pending, required 0", tag, exp_q.size());
      end
   endtask

   // Press the lit mole (optionally with its neighbour); returns clocks until hit_pulse
   task automatic do_hit(input int sc, input int mi, input bit extra, output int lat);
      logic [3:0] m;
      wait_lit(1'b1, "hit_mole");
      m = mole;
      push(1'b0, sc, mi, 1'b1, 1'b0, "hit");
      push(1'b0, sc, mi, 1'b0, 1'b0, "hit_end");
      push(1'b1, sc, mi, 1'b0, 1'b0, "next_mole");
      btn = extra ? (m | {m[2:0], m[3]}) : m;
      lat = 0;
      while (!hit_pulse && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      btn = 4'd0;
   endtask

   // Monitor: pop and compare whenever the observable output state changes
   initial begin : monitor
      bit         p_lit, p_hp, p_go, c_lit, c_hp, c_go;
      int         p_sc, p_mi, c_sc, c_mi;
      logic [3:0] last_m;
      exp_t       e;
      p_lit = 0; p_hp = 0; p_go = 0; p_sc = 0; p_mi = 0; last_m = 4'd0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            p_lit = 0; p_hp = 0; p_go = 0; p_sc = 0; p_mi = 0; last_m = 4'd0;
         end else begin
            c_lit = (mole != 4'd0);
            c_hp  = hit_pulse;
            c_go  = game_over;
            c_sc  = int'(score);
            c_mi  = int'(misses);
            if (c_lit && !p_lit) begin
               n_cmp++;
               if (!$onehot(mole) || mole == last_m) begin
                  n_err++;
                  $display("FAIL mole_pick: got %b, required one-hot and not equal to previous %b",
                           mole, last_m);
               end
               last_m = mole;
            end
            if (c_lit != p_lit || c_hp != p_hp || c_go != p_go || c_sc != p_sc || c_mi != p_mi) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_change: got lit=%0d score=%0d misses=%0d hit=%0d over=%0d, required no change",
                           c_lit, c_sc, c_mi, c_hp, c_go);
               end else begin
                  e = exp_q.pop_front();
                  if (e.lit != c_lit || e.sc != c_sc || e.mi != c_mi || e.hp != c_hp || e.go != c_go) begin
                     n_err++;
                     $display("FAIL %s: got lit=%0d score=%0d misses=%0d hit=%0d over=%0d, required lit=%0d score=%0d misses=%0d hit=%0d over=%0d",
                              e.tag, c_lit, c_sc, c_mi, c_hp, c_go, e.lit, e.sc, e.mi, e.hp, e.go);
                  end
               end
               p_lit = c_lit; p_hp = c_hp; p_go = c_go; p_sc = c_sc; p_mi = c_mi;
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      int         lat;
      int         n;
      logic [3:0] m;
      reset      = 1'b0;
      game_begin = 1'b0;
      btn        = 4'd0;

      repeat (3) @(negedge clk);
      chk("reset_mole", int'(mole), 0);
      chk("reset_score", int'(score), 0);
      chk("reset_misses", int'(misses), 0);
      chk("reset_active", int'(round_active), 0);
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_active", int'(round_active), 0);

      // Round 1: untouched mole times out; measure UP and GAP lengths
      game_begin = 1'b1;
      push(1'b1, 0, 0, 1'b0, 1'b0, "first_mole");
      wait_lit(1'b1, "first_mole");
      chk("up_active", int'(round_active), 1);
      push(1'b0, 0, 1, 1'b0, 1'b0, "timeout");
      count_lit(1'b1, n);
      chk("up_len_clk", n, 24);
      push(1'b1, 0, 1, 1'b0, 1'b0, "second_mole");
      count_lit(1'b0, n);
      chk("gap_len_clk", n, 8);

      // Correct press: scored 3 clk after the button rises
      do_hit(1, 1, 1'b0, lat);
      chk("hit_latency", lat, 3);

      // Wrong press then correct press
      wait_lit(1'b1, "wrong_mole");
      m = mole;
      push(1'b1, 1, 2, 1'b0, 1'b0, "wrong_miss");
      btn = {m[2:0], m[3]};
      repeat (5) @(negedge clk);
      chk("mole_held_wrong", int'(mole), int'(m));
      do_hit(2, 2, 1'b0, lat);

      // Correct and wrong together: hit only
      do_hit(3, 2, 1'b1, lat);

      // game_begin falls in the cycle the correct press is judged
      wait_lit(1'b1, "gb_mole");
      m = mole;
      push(1'b0, 3, 2, 1'b0, 1'b0, "gb_fall");
      btn = m;
      @(negedge clk);
      @(negedge clk);
      game_begin = 1'b0;
      @(negedge clk);
      btn = 4'd0;
      repeat (6) @(negedge clk);
      chk("done_active", int'(round_active), 0);
      chk("done_score_held", int'(score), 3);

      // New round clears counters; then drive score into saturation
      game_begin = 1'b1;
      push(1'b0, 0, 0, 1'b0, 1'b0, "restart_clear");
      push(1'b1, 0, 0, 1'b0, 1'b0, "restart_mole");
      for (int k = 1; k <= 100; k++) begin
         do_hit((k > 99) ? 99 : k, 0, 1'b0, lat);
      end

`ifdef LIVES_EN
      for (int k = 1; k <= 3; k++) begin
         wait_lit(1'b1, "lives_mole");
         push(1'b0, 99, k, 1'b0, 1'b0, "lives_timeout");
         if (k < 3) begin
            wait_lit(1'b0, "lives_gap");
            push(1'b1, 99, k, 1'b0, 1'b0, "lives_next");
         end
      end
      push(1'b0, 99, 3, 1'b0, 1'b1, "game_over");
      wait_q_empty("lives");
      repeat (2) @(negedge clk);
      chk("over_active", int'(round_active), 0);
      game_begin = 1'b0;
`else
      // Timeouts drive misses into saturation at 15
      for (int k = 1; k <= 16; k++) begin
         wait_lit(1'b1, "sat_mole");
         push(1'b0, 99, (k > 15) ? 15 : k, 1'b0, 1'b0, "miss_sat");
         wait_lit(1'b0, "sat_gap");
         push(1'b1, 99, (k > 15) ? 15 : k, 1'b0, 1'b0, "sat_next");
      end
      wait_lit(1'b1, "drop_mole");
      push(1'b0, 99, 15, 1'b0, 1'b0, "gb_drop");
      game_begin = 1'b0;
      wait_q_empty("sat");
      chk("never_over", int'(game_over), 0);
`endif

      // Fresh round, score 5, then asynchronous reset in the middle of UP
      repeat (3) @(negedge clk);
      game_begin = 1'b1;
      push(1'b0, 0, 0, 1'b0, 1'b0, "restart2_clear");
      push(1'b1, 0, 0, 1'b0, 1'b0, "restart2_mole");
      for (int k = 1; k <= 5; k++) begin
         do_hit(k, 0, 1'b0, lat);
      end
      wait_q_empty("pre_reset");
      chk("pre_reset_lit", int'(mole != 4'd0), 1);
      chk("pre_reset_score", int'(score), 5);
      @(posedge clk);
      #2;
      mon_en     = 1'b0;
      reset      = 1'b0;
      game_begin = 1'b0;
      #1;
      chk("arst_mole", int'(mole), 0);
      chk("arst_score", int'(score), 0);
      chk("arst_misses", int'(misses), 0);
      chk("arst_hit", int'(hit_pulse), 0);
      chk("arst_active", int'(round_active), 0);
      chk("arst_over", int'(game_over), 0);
      repeat (3) @(negedge clk);
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_after_reset", int'(round_active), 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
